// File: rtl/nes_vid_pkg.sv
// Shared types and constants for the NES video path: line geometry and the
// bank / read-side state encodings used by the PPU line feeder.
package nes_vid_pkg;

  localparam int NES_LINE_W = 256;
  localparam int NES_PIX_W  = 6;

  typedef enum logic [2:0] {
    EMPTY,
    FILLING,
    FULL,
    ARMED,
    DRAINING
  } bank_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ARMED,
    RD_STREAM
  } rd_state_e;

  // A bank holds a complete line that nobody has started reading yet.
  function automatic logic holds_line(bank_state_e s);
    return s inside {FULL, ARMED};
  endfunction

endpackage

// File: rtl/ppu_line_feeder_if.sv
// PPU-side write signals and VGA-side read signals of the line feeder.
// master drives pixels and read bursts; slave is the feeder itself.
interface ppu_line_feeder_if
  import nes_vid_pkg::*;
#(
  parameter int PIX_W = NES_PIX_W
);

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_sol;
  logic             pix_sof;
  logic             wr_ready;
  logic             reading;
  logic [PIX_W-1:0] c_dat;
  logic             line_ready;
  logic             overrun;
  logic             underrun;

  modport master (
    output pix_in, pix_valid, pix_sol, pix_sof, reading,
    input  wr_ready, c_dat, line_ready, overrun, underrun
  );

  modport slave (
    input  pix_in, pix_valid, pix_sol, pix_sof, reading,
    output wr_ready, c_dat, line_ready, overrun, underrun
  );

endinterface

// File: rtl/line_bank.sv
// One scanline of palette codes: synchronous write port, asynchronous read
// port so the read side can register the next pixel in the same cycle.
module line_bank #(
  parameter int DEPTH = 256,
  parameter int W     = 6
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; bank state, not contents, says what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ppu_line_feeder.sv
// Ping-pong scanline buffer: PPU pixels fill one bank while the VGA stage
// streams the other with zero latency relative to its reading strobe.
module ppu_line_feeder
  import nes_vid_pkg::*;
#(
  parameter int LINE_W = NES_LINE_W,
  parameter int PIX_W  = NES_PIX_W
) (
  input logic              clk,
  input logic              reset,
  ppu_line_feeder_if.slave bus
);

  localparam int             X_W    = $clog2(LINE_W);
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);

  bank_state_e      bank_st [2];
  logic             wr_bank;
  logic             rd_bank;
  logic [X_W-1:0]   wr_x;
  logic [X_W-1:0]   rd_x;
  rd_state_e        rd_state;
  logic             reading_q;
  logic [PIX_W-1:0] c_dat_q;
  logic             line_ready_q;
  logic             overrun_q;
  logic             underrun_q;

  logic [PIX_W-1:0] bank_rdata [2];
  logic [PIX_W-1:0] rd_pix;
  logic [X_W-1:0]   wr_addr;
  logic [X_W-1:0]   rd_addr;
  logic             wr_ready;
  logic             wr_en;
  logic             sol_acc;
  logic             sof_acc;
  logic             line_done;
  logic             short_line;
  logic             rd_arm;
  logic             rd_start;
  logic             rd_release;
  logic             rd_drop;

  // NOTE: every signal here is assigned on every pass, so no latches are inferred.
  always_comb begin
    wr_ready   = bank_st[wr_bank] inside {EMPTY, FILLING};
    wr_en      = bus.pix_valid && wr_ready;
    sol_acc    = wr_en && (bus.pix_sol || bus.pix_sof);
    sof_acc    = wr_en && bus.pix_sof;
    wr_addr    = sol_acc ? '0 : wr_x;
    line_done  = wr_en && (wr_addr == X_LAST);
    short_line = sol_acc && (bank_st[wr_bank] == FILLING) && (wr_x != '0);
    // Arming needs reading low, so a line finishing mid-burst waits for the next burst.
    rd_arm     = (rd_state == RD_IDLE) && !bus.reading &&
                 (bank_st[rd_bank] == FULL) && !sof_acc;
    rd_start   = (rd_state == RD_ARMED) && bus.reading;
    rd_drop    = (rd_state == RD_ARMED) && !bus.reading && sof_acc;
    rd_release = (rd_state == RD_STREAM) && (!bus.reading || rd_x == X_LAST);
    rd_addr    = (rd_state == RD_IDLE) ? '0 : rd_x + X_W'(1);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_bank #(.DEPTH(LINE_W), .W(PIX_W)) u_bank (
      .clk  (clk),
      .we   (wr_en && (wr_bank == 1'(b))),
      .waddr(wr_addr),
      .wdata(bus.pix_in),
      .raddr(rd_addr),
      .rdata(bank_rdata[b])
    );
  end

  assign rd_pix = bank_rdata[rd_bank];

  // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) bank_st[b] <= EMPTY;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_x         <= '0;
      rd_x         <= '0;
      rd_state     <= RD_IDLE;
      reading_q    <= 1'b0;
      c_dat_q      <= '0;
      line_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      reading_q    <= bus.reading;
      overrun_q    <= (bus.pix_valid && !wr_ready) || short_line;
      underrun_q   <= (rd_state == RD_IDLE) && bus.reading && !reading_q;
      line_ready_q <= holds_line(bank_st[0]) || holds_line(bank_st[1]);

      // Write and read never act on the same bank, so at most one branch applies per bank.
      for (int b = 0; b < 2; b++) begin
        if (wr_en && wr_bank == 1'(b))
          bank_st[b] <= line_done ? FULL : FILLING;
        else if (rd_release && rd_bank == 1'(b))
          bank_st[b] <= EMPTY;
        else if (rd_start && rd_bank == 1'(b))
          bank_st[b] <= DRAINING;
        else if (rd_arm && rd_bank == 1'(b))
          bank_st[b] <= ARMED;
        else if (sof_acc && holds_line(bank_st[b]))
          bank_st[b] <= EMPTY;
      end

      if (wr_en) begin
        wr_x <= line_done ? '0 : wr_addr + X_W'(1);
        if (line_done) wr_bank <= !wr_bank;
      end

      // A live drain keeps its bank; the reader reaches wr_bank when that drain ends.
      if (rd_release)
        rd_bank <= !rd_bank;
      else if (sof_acc && !rd_start && rd_state != RD_STREAM)
        rd_bank <= wr_bank;

      unique case (rd_state)
        RD_IDLE: begin
          if (rd_arm) begin
            rd_state <= RD_ARMED;
            rd_x     <= '0;
            c_dat_q  <= rd_pix;
          end else begin
            c_dat_q  <= '0;
          end
        end
        RD_ARMED: begin
          if (rd_start) begin
            rd_state <= RD_STREAM;
            rd_x     <= rd_x + X_W'(1);
            c_dat_q  <= rd_pix;
          end else if (rd_drop) begin
            rd_state <= RD_IDLE;
            c_dat_q  <= '0;
          end
        end
        RD_STREAM: begin
          if (rd_release) begin
            rd_state <= RD_IDLE;
            c_dat_q  <= '0;
          end else begin
            rd_x     <= rd_x + X_W'(1);
            c_dat_q  <= rd_pix;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.c_dat      = c_dat_q;
  assign bus.line_ready = line_ready_q;
  assign bus.overrun    = overrun_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_ppu_line_feeder.sv
// Directed bench for ppu_line_feeder: a table of line/burst vectors plus
// hand-written sequences for back-pressure, short line, underrun and resets.
module tb_ppu_line_feeder;
  import nes_vid_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ppu_line_feeder_if #(.PIX_W(NES_PIX_W)) bus ();

  ppu_line_feeder #(.LINE_W(NES_LINE_W), .PIX_W(NES_PIX_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int   off;
    int   mul;
    int   rd_len;
    logic exp_lr_armed;
    logic exp_lr_after;
  } vec_t;

  vec_t vecs [5];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [5:0] pat(int off, int mul, int x);
    return 6'((off + mul * x) % 64);
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sol   = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.reading   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic put_pixel(logic [5:0] v, logic sol, logic sof);
    bus.pix_valid = 1'b1;
    bus.pix_in    = v;
    bus.pix_sol   = sol;
    bus.pix_sof   = sof;
    tick();
    bus.pix_valid = 1'b0;
    bus.pix_sol   = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic write_line(int off, int mul, logic sof);
    for (int x = 0; x < 256; x++) put_pixel(pat(off, mul, x), x == 0, sof && x == 0);
  endtask

  // Pixel k of the burst must be on c_dat during the k-th high cycle; zero past the line.
  task automatic read_burst(string tag, int off, int mul, int len);
    for (int k = 0; k < len; k++) begin
      bus.reading = 1'b1;
      check($sformatf("%s_c_dat_px%0d", tag, k), bus.c_dat, (k < 256) ? int'(pat(off, mul, k)) : 0);
      if (k == 1) check($sformatf("%s_no_underrun", tag), bus.underrun, 0);
      tick();
    end
    bus.reading = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{off: 0,  mul: 1,  rd_len: 256, exp_lr_armed: 1'b1, exp_lr_after: 1'b0};
    vecs[1] = '{off: 5,  mul: 3,  rd_len: 256, exp_lr_armed: 1'b1, exp_lr_after: 1'b0};
    vecs[2] = '{off: 63, mul: 7,  rd_len: 258, exp_lr_armed: 1'b1, exp_lr_after: 1'b0};
    vecs[3] = '{off: 17, mul: 1,  rd_len: 128, exp_lr_armed: 1'b1, exp_lr_after: 1'b0};
    vecs[4] = '{off: 42, mul: 11, rd_len: 256, exp_lr_armed: 1'b1, exp_lr_after: 1'b0};

    do_reset();
    check("rst_c_dat",      bus.c_dat,      0);
    check("rst_wr_ready",   bus.wr_ready,   1);
    check("rst_line_ready", bus.line_ready, 0);
    check("rst_overrun",    bus.overrun,    0);
    check("rst_underrun",   bus.underrun,   0);

    // Table: one line written, armed, then a burst of rd_len cycles.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("vec%0d_wr_ready_pre", i), bus.wr_ready, 1);
      write_line(vecs[i].off, vecs[i].mul, 1'b0);
      tick();
      check($sformatf("vec%0d_line_ready_armed", i), bus.line_ready, int'(vecs[i].exp_lr_armed));
      read_burst($sformatf("vec%0d", i), vecs[i].off, vecs[i].mul, vecs[i].rd_len);
      check($sformatf("vec%0d_line_ready_after", i), bus.line_ready, int'(vecs[i].exp_lr_after));
      check($sformatf("vec%0d_wr_ready_after", i), bus.wr_ready, 1);
    end

    // Back-pressure: two unread lines block the writer; a refused pixel flags overrun.
    do_reset();
    write_line(1, 1, 1'b0);
    write_line(2, 5, 1'b0);
    check("bp_wr_ready_low", bus.wr_ready, 0);
    check("bp_line_ready", bus.line_ready, 1);
    put_pixel(pat(3, 1, 0), 1'b1, 1'b0);
    check("bp_overrun", bus.overrun, 1);
    tick();
    check("bp_overrun_pulse_end", bus.overrun, 0);
    read_burst("bp_l1", 1, 1, 256);
    check("bp_wr_ready_back", bus.wr_ready, 1);
    tick();
    read_burst("bp_l2", 2, 5, 256);

    // Short line: 100 pixels then a new start-of-line.
    do_reset();
    for (int x = 0; x < 100; x++) put_pixel(pat(50, 1, x), x == 0, 1'b0);
    check("sl_no_overrun_yet", bus.overrun, 0);
    put_pixel(pat(9, 5, 0), 1'b1, 1'b0);
    check("sl_overrun", bus.overrun, 1);
    put_pixel(pat(9, 5, 1), 1'b0, 1'b0);
    check("sl_overrun_pulse_end", bus.overrun, 0);
    for (int x = 2; x < 256; x++) put_pixel(pat(9, 5, x), 1'b0, 1'b0);
    tick();
    check("sl_line_ready", bus.line_ready, 1);
    read_burst("sl", 9, 5, 256);

    // Underrun: burst with nothing armed; the line finishing mid-burst waits.
    do_reset();
    for (int x = 0; x < 250; x++) put_pixel(pat(21, 1, x), x == 0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      bus.reading   = 1'b1;
      bus.pix_valid = (k < 6);
      bus.pix_in    = pat(21, 1, 250 + k);
      check($sformatf("ur_c_dat_k%0d", k), bus.c_dat, 0);
      if (k == 1) check("ur_pulse", bus.underrun, 1);
      if (k == 2) check("ur_pulse_end", bus.underrun, 0);
      tick();
    end
    idle_inputs();
    tick();
    check("ur_line_ready", bus.line_ready, 1);
    read_burst("ur_next", 21, 1, 256);

    // Early release: 128-pixel burst frees the bank; next burst starts the next line.
    do_reset();
    write_line(9, 1, 1'b0);
    write_line(33, 3, 1'b0);
    check("er_wr_ready_low", bus.wr_ready, 0);
    read_burst("er_l1", 9, 1, 128);
    check("er_wr_ready_back", bus.wr_ready, 1);
    tick();
    read_burst("er_l2", 33, 3, 256);

    // Frame reset: armed line dropped, partial line restarted by the SOF pixel.
    do_reset();
    write_line(11, 1, 1'b0);
    for (int x = 0; x < 50; x++) put_pixel(pat(77, 1, x), x == 0, 1'b0);
    check("sof_line_ready_pre", bus.line_ready, 1);
    put_pixel(pat(40, 2, 0), 1'b1, 1'b1);
    check("sof_overrun", bus.overrun, 1);
    put_pixel(pat(40, 2, 1), 1'b0, 1'b0);
    check("sof_line_ready_dropped", bus.line_ready, 0);
    for (int x = 2; x < 256; x++) put_pixel(pat(40, 2, x), 1'b0, 1'b0);
    tick();
    check("sof_line_ready_new", bus.line_ready, 1);
    read_burst("sof", 40, 2, 256);
    check("sof_line_ready_after", bus.line_ready, 0);

    // Mid-burst reset overrides a refused write and a live burst.
    do_reset();
    write_line(50, 1, 1'b0);
    write_line(7, 1, 1'b0);
    for (int k = 0; k < 50; k++) begin
      bus.reading = 1'b1;
      tick();
    end
    check("mr_c_dat_before", bus.c_dat, int'(pat(50, 1, 50)));
    check("mr_wr_ready_before", bus.wr_ready, 0);
    bus.pix_valid = 1'b1;
    bus.pix_sol   = 1'b1;
    reset = 1'b1;
    tick();
    check("mr_c_dat",      bus.c_dat,      0);
    check("mr_wr_ready",   bus.wr_ready,   1);
    check("mr_line_ready", bus.line_ready, 0);
    check("mr_overrun",    bus.overrun,    0);
    check("mr_underrun",   bus.underrun,   0);
    reset = 1'b0;
    idle_inputs();
    tick();
    check("mr_line_ready_post", bus.line_ready, 0);
    check("mr_wr_ready_post",   bus.wr_ready,   1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
